ps2_send_module: RTL and testbench
==================================

Name: ps2_send_module

Overview:
Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) to a keyboard over the open-drain PS/2 lines.
Runs the full sequence: clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, then checks the device ACK.
Shares the falling-edge pulse H2L_Sig with the PS/2 receive path. Tx_Busy gates that receive path while a transmission is in progress.
Drives the lines via active-high pull-low enables; the top level builds the tri-state pads.

Parameters:
INHIBIT_CYCLES, 5000, CLK cycles the PS/2 clock is held low before request (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max CLK cycles allowed between device clock falling edges (15 ms at 50 MHz); counter width 20 bits

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
H2L_Sig  input  1  one-CLK pulse per PS/2 clock high-to-low edge (synchronised upstream)
PS2_Data_Pin_In  input  1  synchronised PS/2 data line level
Tx_Start_Sig  input  1  one-CLK request to send Tx_Data
Tx_Data  input  8  byte to send, sampled with Tx_Start_Sig
PS2_Clk_Oe  output  1  1 = pull PS/2 clock low, 0 = release
PS2_Data_Oe  output  1  1 = pull PS/2 data low, 0 = release
Tx_Busy  output  1  high from accepted start until Done/Err pulse inclusive
Tx_Done_Sig  output  1  one-CLK pulse: byte sent and ACK received
Tx_Err_Sig  output  1  one-CLK pulse: no ACK or timeout

Behaviour:
- Reset (async, any time including mid-transfer): all outputs 0, state IDLE, lines released, counters 0.
- IDLE: on Tx_Start_Sig, latch rShift = {stop=1, parity=~^Tx_Data, Tx_Data}, the 10-bit frame after the start bit. Next cycle goes to INHIBIT, with Tx_Busy=1 and PS2_Clk_Oe=1.
- Tx_Start_Sig while Tx_Busy=1 is ignored; the latched data is unchanged.
- INHIBIT: PS2_Clk_Oe=1 for exactly INHIBIT_CYCLES cycles. The last of those cycles goes to REQ.
- REQ (1 cycle): PS2_Clk_Oe=1, PS2_Data_Oe=1 (start bit 0). Next cycle goes to SEND, with PS2_Clk_Oe=0 and PS2_Data_Oe still 1.
- SEND, bit index rIndex 0..9: on each H2L_Sig, PS2_Data_Oe <= ~rShift[rIndex] and rIndex increments.
  - rIndex 0..7 are data bits D0..D7, 8 is parity, 9 is stop, so PS2_Data_Oe=0 after the 10th edge.
  - The new data value appears the cycle after the H2L_Sig pulse.
- ACK: on the 11th H2L_Sig, sample PS2_Data_Pin_In.
  - 0: go to DONE.
  - 1: go to ERR.
- DONE/ERR (1 cycle): pulse Tx_Done_Sig or Tx_Err_Sig, lines released, Tx_Busy=1 this cycle. Next cycle returns to IDLE with Tx_Busy=0.
- Timeout, in SEND and ACK only:
  - The counter clears on entry and on every H2L_Sig.
  - On reaching TIMEOUT_CYCLES, release both lines and go to ERR.
- H2L_Sig is ignored in IDLE, INHIBIT and REQ.
- Tx_Done_Sig and Tx_Err_Sig are never high in the same cycle.
- Parity is odd over 8 data bits. Examples: 0x00 -> 1, 0xFF -> 1, 0xED -> 1, 0x01 -> 0.
- A new Tx_Start_Sig in the cycle Tx_Busy falls is accepted normally.

Test Plan:
- Send 0xED, device model clocks 11 edges and pulls data low on the 11th:
  - PS2_Clk_Oe high for 5000 cycles + 1 REQ cycle.
  - PS2_Data_Oe sequence after each edge: start 1, then bits 0,1,0,0,1,0,0,0 (data 1,0,1,1,0,1,1,1), parity 0 (bit=1), stop 0.
  - Tx_Done_Sig pulses once.
- Send 0x00, then 0x01: parity bit 1 (Data_Oe=0) and 0 (Data_Oe=1) respectively; both end with a Done pulse.
- Device leaves data high at the 11th edge -> Tx_Err_Sig pulse, no Tx_Done_Sig, Tx_Busy drops the cycle after.
- Device stops clocking after 4 edges -> exactly 750000 cycles after the 4th edge, lines released and Tx_Err_Sig pulse.
- Tx_Start_Sig with 0xAA during INHIBIT of a 0xFF send -> frame still carries 0xFF, with a single Done pulse.
- RSTn low mid-SEND (after 5 edges) -> all outputs 0 immediately. After release, a fresh 0xF4 send completes with Done.

Source files
------------

// File: rtl/ps2_send_module.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, then device ACK check. Lines driven through pull-low enables.
module ps2_send_module #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       H2L_Sig,
  input  logic       PS2_Data_Pin_In,
  input  logic       Tx_Start_Sig,
  input  logic [7:0] Tx_Data,
  output logic       PS2_Clk_Oe,
  output logic       PS2_Data_Oe,
  output logic       Tx_Busy,
  output logic       Tx_Done_Sig,
  output logic       Tx_Err_Sig
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    DONE,
    ERR
  } state_t;

  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic [9:0]  shift_reg;
  logic [3:0]  index_reg;
  logic [19:0] cnt_reg;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      index_reg   <= '0;
      cnt_reg     <= '0;
      PS2_Clk_Oe  <= 1'b0;
      PS2_Data_Oe <= 1'b0;
      Tx_Busy     <= 1'b0;
      Tx_Done_Sig <= 1'b0;
      Tx_Err_Sig  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Tx_Start_Sig) begin
            // Frame after the start bit: stop, odd parity, data (sent LSB first)
            shift_reg   <= {1'b1, ~^Tx_Data, Tx_Data};
            index_reg   <= '0;
            cnt_reg     <= '0;
            Tx_Busy     <= 1'b1;
            PS2_Clk_Oe  <= 1'b1;
            PS2_Data_Oe <= 1'b0;
            state_reg   <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (cnt_reg == INHIBIT_LAST) begin
            cnt_reg     <= '0;
            PS2_Data_Oe <= 1'b1;
            state_reg   <= REQ;
          end else begin
            cnt_reg <= cnt_reg + 20'd1;
          end
        end

        REQ: begin
          // Release the clock with data held low: the device starts clocking
          PS2_Clk_Oe <= 1'b0;
          cnt_reg    <= '0;
          state_reg  <= SEND;
        end

        SEND: begin
          if (H2L_Sig) begin
            PS2_Data_Oe <= ~shift_reg[index_reg];
            index_reg   <= index_reg + 4'd1;
            cnt_reg     <= '0;
            if (index_reg == 4'd9) begin
              state_reg <= ACK;
            end
          end else if (cnt_reg == TIMEOUT_LAST) begin
            PS2_Clk_Oe  <= 1'b0;
            PS2_Data_Oe <= 1'b0;
            Tx_Err_Sig  <= 1'b1;
            state_reg   <= ERR;
          end else begin
            cnt_reg <= cnt_reg + 20'd1;
          end
        end

        ACK: begin
          if (H2L_Sig) begin
            cnt_reg     <= '0;
            PS2_Clk_Oe  <= 1'b0;
            PS2_Data_Oe <= 1'b0;
            if (!PS2_Data_Pin_In) begin
              Tx_Done_Sig <= 1'b1;
              state_reg   <= DONE;
            end else begin
              Tx_Err_Sig <= 1'b1;
              state_reg  <= ERR;
            end
          end else if (cnt_reg == TIMEOUT_LAST) begin
            PS2_Clk_Oe  <= 1'b0;
            PS2_Data_Oe <= 1'b0;
            Tx_Err_Sig  <= 1'b1;
            state_reg   <= ERR;
          end else begin
            cnt_reg <= cnt_reg + 20'd1;
          end
        end

        DONE, ERR: begin
          Tx_Done_Sig <= 1'b0;
          Tx_Err_Sig  <= 1'b0;
          Tx_Busy     <= 1'b0;
          cnt_reg     <= '0;
          state_reg   <= IDLE;
        end

        default: begin
          PS2_Clk_Oe  <= 1'b0;
          PS2_Data_Oe <= 1'b0;
          Tx_Busy     <= 1'b0;
          Tx_Done_Sig <= 1'b0;
          Tx_Err_Sig  <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_send_module.sv
// Bench for ps2_send_module: a PS/2 device model clocks frames back and checks
// them against a byte-level model of the PS/2 host-to-device frame.
module tb_ps2_send_module;

  localparam int INHIB = 200;
  localparam int TOUT  = 3000;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       H2L_Sig = 1'b0;
  logic       PS2_Data_Pin_In = 1'b1;
  logic       Tx_Start_Sig = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       PS2_Clk_Oe;
  logic       PS2_Data_Oe;
  logic       Tx_Busy;
  logic       Tx_Done_Sig;
  logic       Tx_Err_Sig;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  // Observations gathered by the stimulus tasks
  int   obs_inhibit;
  logic obs_req_data;
  logic obs_pre_data;
  logic obs_oe [0:10];
  logic obs_done, obs_err, obs_busy_pulse, obs_busy_after;

  ps2_send_module #(
    .INHIBIT_CYCLES(INHIB),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .H2L_Sig        (H2L_Sig),
    .PS2_Data_Pin_In(PS2_Data_Pin_In),
    .Tx_Start_Sig   (Tx_Start_Sig),
    .Tx_Data        (Tx_Data),
    .PS2_Clk_Oe     (PS2_Clk_Oe),
    .PS2_Data_Oe    (PS2_Data_Oe),
    .Tx_Busy        (Tx_Busy),
    .Tx_Done_Sig    (Tx_Done_Sig),
    .Tx_Err_Sig     (Tx_Err_Sig)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RSTn) begin
      if (Tx_Done_Sig) done_cnt++;
      if (Tx_Err_Sig) err_cnt++;
      if (Tx_Done_Sig && Tx_Err_Sig) both_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pull-low enable on the data line after edge k (k=0: start bit)
  function automatic logic exp_oe(input logic [7:0] d, input int k);
    int ones;
    logic parity;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    parity = ((ones % 2) == 0);
    if (k == 0) return 1'b1;
    if (k <= 8) return !d[k-1];
    if (k == 9) return !parity;
    return 1'b0;
  endfunction

  task automatic start_tx(input logic [7:0] d);
    Tx_Data = d;
    Tx_Start_Sig = 1'b1;
    @(negedge CLK);
    Tx_Start_Sig = 1'b0;
  endtask

  task automatic run_inhibit(input bit inject, input logic [7:0] junk);
    int guard;
    guard = 0;
    obs_inhibit = 0;
    obs_req_data = 1'b0;
    obs_pre_data = 1'b0;
    while (PS2_Clk_Oe === 1'b1 && guard < INHIB + 50) begin
      obs_inhibit++;
      obs_pre_data = obs_pre_data | obs_req_data;
      obs_req_data = PS2_Data_Oe;
      if (inject && obs_inhibit == 10) begin
        Tx_Data = junk;
        Tx_Start_Sig = 1'b1;
      end else begin
        Tx_Start_Sig = 1'b0;
      end
      @(negedge CLK);
      guard++;
    end
    Tx_Start_Sig = 1'b0;
    obs_oe[0] = PS2_Data_Oe;
  endtask

  task automatic clock_edges(input int n, input logic ack_level);
    for (int k = 1; k <= n; k++) begin
      repeat ($urandom_range(1, 8)) @(negedge CLK);
      if (k == 11) PS2_Data_Pin_In = ack_level;
      H2L_Sig = 1'b1;
      @(negedge CLK);
      H2L_Sig = 1'b0;
      if (k <= 10) begin
        obs_oe[k] = PS2_Data_Oe;
      end else begin
        obs_done = Tx_Done_Sig;
        obs_err = Tx_Err_Sig;
        obs_busy_pulse = Tx_Busy;
        @(negedge CLK);
        obs_busy_after = Tx_Busy;
        PS2_Data_Pin_In = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    n_tests++;
    if ({PS2_Clk_Oe, PS2_Data_Oe, Tx_Busy, Tx_Done_Sig, Tx_Err_Sig} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want 00000",
               {PS2_Clk_Oe, PS2_Data_Oe, Tx_Busy, Tx_Done_Sig, Tx_Err_Sig});
    end
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_send(input logic [7:0] d, input bit inject, input string name);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    n_tests++;
    if (Tx_Busy !== 1'b1 || PS2_Clk_Oe !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: busy=%b clk_oe=%b, want 1 1", name, Tx_Busy, PS2_Clk_Oe);
    end
    run_inhibit(inject, 8'hAA);
    n_tests++;
    if (obs_inhibit !== INHIB + 1) begin
      n_fail++;
      $display("FAIL %s clk_low_cycles: got %0d, want %0d", name, obs_inhibit, INHIB + 1);
    end
    n_tests++;
    if (obs_req_data !== 1'b1 || obs_pre_data !== 1'b0) begin
      n_fail++;
      $display("FAIL %s req_data: req=%b pre=%b, want 1 0", name, obs_req_data, obs_pre_data);
    end
    clock_edges(11, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      n_tests++;
      if (obs_oe[k] !== exp_oe(d, k)) begin
        n_fail++;
        $display("FAIL %s data_oe[%0d]: got %b, want %b", name, k, obs_oe[k], exp_oe(d, k));
      end
    end
    n_tests++;
    if (obs_done !== 1'b1 || obs_err !== 1'b0 || obs_busy_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b err=%b busy=%b, want 1 0 1",
               name, obs_done, obs_err, obs_busy_pulse);
    end
    n_tests++;
    if (obs_busy_after !== 1'b0 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL %s end: busy=%b dones=%0d errs=%0d, want 0 1 0",
               name, obs_busy_after, done_cnt - d0, err_cnt - e0);
    end
    $display("[TB] send %s 0x%02h: inhibit=%0d done=%b", name, d, obs_inhibit, obs_done);
  endtask

  task automatic test_parity();
    test_send(8'h00, 1'b0, "par00");
    n_tests++;
    if (obs_oe[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_00: data_oe=%b, want 0", obs_oe[9]);
    end
    test_send(8'h01, 1'b0, "par01");
    n_tests++;
    if (obs_oe[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_01: data_oe=%b, want 1", obs_oe[9]);
    end
  endtask

  task automatic test_nack();
    int d0, e0;
    logic [7:0] d;
    d = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    run_inhibit(1'b0, 8'h00);
    clock_edges(11, 1'b1);
    n_tests++;
    if (obs_err !== 1'b1 || obs_done !== 1'b0 || obs_busy_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL nack_pulse: err=%b done=%b busy=%b, want 1 0 1",
               obs_err, obs_done, obs_busy_pulse);
    end
    n_tests++;
    if (obs_busy_after !== 1'b0 || done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL nack_end: busy=%b dones=%0d errs=%0d, want 0 0 1",
               obs_busy_after, done_cnt - d0, err_cnt - e0);
    end
    $display("[TB] nack 0x%02h: err=%b", d, obs_err);
  endtask

  task automatic test_timeout();
    int cyc;
    start_tx(8'($urandom));
    run_inhibit(1'b0, 8'h00);
    clock_edges(4, 1'b1);
    cyc = 0;
    while (Tx_Err_Sig !== 1'b1 && cyc < TOUT + 100) begin
      @(negedge CLK);
      cyc++;
    end
    n_tests++;
    if (cyc !== TOUT) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d, want %0d", cyc, TOUT);
    end
    n_tests++;
    if (PS2_Clk_Oe !== 1'b0 || PS2_Data_Oe !== 1'b0 || Tx_Busy !== 1'b1 || Tx_Done_Sig !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_lines: clk_oe=%b data_oe=%b busy=%b done=%b, want 0 0 1 0",
               PS2_Clk_Oe, PS2_Data_Oe, Tx_Busy, Tx_Done_Sig);
    end
    @(negedge CLK);
    n_tests++;
    if (Tx_Busy !== 1'b0 || Tx_Err_Sig !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_end: busy=%b err=%b, want 0 0", Tx_Busy, Tx_Err_Sig);
    end
    $display("[TB] timeout after 4 edges: %0d cycles", cyc);
  endtask

  task automatic test_ignore_start();
    test_send(8'hFF, 1'b1, "ignore");
    repeat (5) @(negedge CLK);
    n_tests++;
    if (Tx_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_idle: busy=%b, want 0", Tx_Busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'($urandom) & 8'hEF;
    start_tx(d);
    run_inhibit(1'b0, 8'h00);
    clock_edges(5, 1'b1);
    RSTn = 1'b0;
    #1;
    n_tests++;
    if ({PS2_Clk_Oe, PS2_Data_Oe, Tx_Busy, Tx_Done_Sig, Tx_Err_Sig} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b, want 00000",
               {PS2_Clk_Oe, PS2_Data_Oe, Tx_Busy, Tx_Done_Sig, Tx_Err_Sig});
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    $display("[TB] reset mid-send of 0x%02h", d);
    test_send(8'hF4, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    test_send(8'($urandom), 1'b0, "b2b_a");
    test_send(8'($urandom), 1'b0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_send(8'hED, 1'b0, "led");
    test_parity();
    for (int i = 0; i < 4; i++) test_send(8'($urandom), 1'b0, "rand");
    test_nack();
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    n_tests++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL done_err_overlap: got %0d cycles, want 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
